// File: rtl/regfile_param.sv
// Parametrised register file: one synchronous write port, two combinational
// read ports, optional hardwired-zero entry 0 and optional write-to-read bypass.
module regfile_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_b
);

  // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wrValid;

  function automatic logic addrInRange(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < DEPTH_L;
  endfunction

  function automatic logic addrIsZeroReg(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  // A write that actually lands; it is also the only write eligible for bypass.
  always_comb begin
    wrValid = wr_en && !reset && addrInRange(wr_addr) && !addrIsZeroReg(wr_addr);
  end

  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      mem_d[e] = mem_q[e];
    end
    if (wrValid) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem_q[e] <= '0;
      end
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        mem_q[e] <= mem_d[e];
      end
    end
  end

  // Priority: forced zero, then same-cycle bypass, then the stored entry.
  function automatic logic [WIDTH-1:0] readPort(input logic [ADDR_W-1:0] addr);
    logic [WIDTH-1:0] data;
    data = '0;
    if (reset || !addrInRange(addr) || addrIsZeroReg(addr)) begin
      data = '0;
    end else if ((BYPASS != 0) && wrValid && (wr_addr == addr)) begin
      data = wr_data;
    end else begin
      data = mem_q[addr];
    end
    return data;
  endfunction

  always_comb begin
    rd_data_a = readPort(rd_addr_a);
  end

  always_comb begin
    rd_data_b = readPort(rd_addr_b);
  end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three configurations share one stimulus stream and
// are checked every cycle against an array-based model of the register file.
module tb_regfile_param;

  localparam int NINST = 3;
  localparam int AW    = 5;

  // Instance 0: default (32 deep, zero reg, bypass).
  // Instance 1: 32 deep, no zero reg, no bypass.
  // Instance 2: 24 deep, zero reg, bypass.
  localparam int INST_DEPTH [NINST] = '{32, 32, 24};
  localparam int INST_ZERO  [NINST] = '{1, 0, 1};
  localparam int INST_BYP   [NINST] = '{1, 0, 1};

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [31:0]   wr_data = '0;
  logic [AW-1:0] rd_addr_a = '0;
  logic [AW-1:0] rd_addr_b = '0;
  logic [31:0]   rdA [NINST];
  logic [31:0]   rdB [NINST];

  logic [31:0] model [NINST][32];
  int          vecCount = 0;
  int          missCount = 0;
  logic        checkEn = 1'b0;

  always #5 clk = ~clk;

  regfile_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) u_def (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rdA[0]), .rd_addr_b(rd_addr_b), .rd_data_b(rdB[0]));

  regfile_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(0), .BYPASS(0)) u_plain (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rdA[1]), .rd_addr_b(rd_addr_b), .rd_data_b(rdB[1]));

  regfile_param #(.WIDTH(32), .DEPTH(24), .ZERO_REG(1), .BYPASS(1)) u_d24 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rdA[2]), .rd_addr_b(rd_addr_b), .rd_data_b(rdB[2]));

  function automatic bit writeLands(input int inst);
    int wa;
    wa = int'(wr_addr);
    return wr_en && !reset && (wa < INST_DEPTH[inst]) && !(INST_ZERO[inst] == 1 && wa == 0);
  endfunction

  function automatic logic [31:0] modelRead(input int inst, input int addr);
    if (reset) return 32'h0;
    if (addr >= INST_DEPTH[inst]) return 32'h0;
    if (INST_ZERO[inst] == 1 && addr == 0) return 32'h0;
    if (INST_BYP[inst] == 1 && writeLands(inst) && int'(wr_addr) == addr) return wr_data;
    return model[inst][addr];
  endfunction

  // Architectural state of each configuration: cleared by reset, loaded by landed writes.
  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < NINST; i++) begin
      if (reset) begin
        for (int a = 0; a < 32; a++) model[i][a] <= 32'h0;
      end else if (writeLands(i)) begin
        model[i][int'(wr_addr)] <= wr_data;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [AW-1:0] wa, input logic [31:0] wd,
                               input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    rd_addr_a = ra;
    rd_addr_b = rb;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle comparison of every configuration and both ports against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      for (int i = 0; i < NINST; i++) begin
        checkOutput($sformatf("inst%0d portA addr%0d", i, rd_addr_a), rdA[i], modelRead(i, int'(rd_addr_a)));
        checkOutput($sformatf("inst%0d portB addr%0d", i, rd_addr_b), rdB[i], modelRead(i, int'(rd_addr_b)));
      end
    end
  end

  initial begin
    #1 reset = 1'b1;
    #2;
    checkOutput("resetA", rdA[0], 32'h0);
    checkOutput("resetB", rdB[1], 32'h0);
    reset = 1'b0;
    checkEn = 1'b1;

    for (int a = 0; a < 32; a++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a));
      tick();
    end

    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd6);
    #1;
    checkOutput("noBypassOld", rdA[1], 32'h0);
    checkOutput("bypassFwd", rdA[0], 32'hDEADBEEF);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd6);
    #1;
    checkOutput("noBypassNew", rdA[1], 32'hDEADBEEF);
    checkOutput("neighbourB", rdB[1], 32'h0);
    tick();

    applyStimulus(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7);
    #1;
    checkOutput("bypassA", rdA[0], 32'h12345678);
    checkOutput("bypassB", rdB[0], 32'h12345678);
    tick();
    applyStimulus(1'b0, 5'd8, 32'h55555555, 5'd7, 5'd7);
    #1;
    checkOutput("bypassHeld", rdA[0], 32'h12345678);
    tick();

    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    #1;
    checkOutput("zeroRegA", rdA[0], 32'h0);
    checkOutput("zeroRegB", rdB[0], 32'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #1;
    checkOutput("zeroRegAfter", rdA[0], 32'h0);
    checkOutput("noZeroReg", rdA[1], 32'hFFFFFFFF);
    tick();

    applyStimulus(1'b1, 5'd30, 32'h000000A5, 5'd30, 5'd23);
    #1;
    checkOutput("d24OutOfRange", rdA[2], 32'h0);
    checkOutput("d32BypassAddr30", rdA[0], 32'h000000A5);
    tick();
    applyStimulus(1'b1, 5'd23, 32'h000000A5, 5'd30, 5'd23);
    #1;
    checkOutput("d24LastBypass", rdB[2], 32'h000000A5);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd30, 5'd23);
    #1;
    checkOutput("d24Addr30Stays0", rdA[2], 32'h0);
    checkOutput("d24Addr23", rdB[2], 32'h000000A5);
    checkOutput("d32Addr30", rdA[1], 32'h000000A5);
    tick();

    for (int a = 1; a <= 3; a++) begin
      applyStimulus(1'b1, 5'(a), 32'(a), 5'd0, 5'd0);
      tick();
    end
    applyStimulus(1'b1, 5'd2, 32'h99, 5'd2, 5'd3);
    #1;
    checkOutput("preResetBypass", rdA[0], 32'h99);
    checkOutput("preResetStored", rdB[0], 32'h3);
    #1 reset = 1'b1;
    #1;
    checkOutput("asyncClearA", rdA[0], 32'h0);
    checkOutput("asyncClearB", rdB[1], 32'h0);
    tick();
    #1 reset = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd2, 5'd3);
    tick();
    #1;
    checkOutput("lostWriteA", rdA[0], 32'h0);
    checkOutput("clearedB", rdB[1], 32'h0);

    for (int a = 0; a < 32; a++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 5'(a), 5'(a));
      tick();
    end

    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
